// File: rtl/u712_pkg.sv
// Shared encodings for the U712 chip-register sizer: 68040 size codes, beat limits, FSM states.
package u712_pkg;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;

  // Index of the final beat for each transfer class.
  localparam logic [2:0] LAST_BEAT_SINGLE = 3'd0;
  localparam logic [2:0] LAST_BEAT_LONG   = 3'd1;
  localparam logic [2:0] LAST_BEAT_LINE   = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StWaitIdle,
    StReq,
    StDrain,
    StAck,
    StErr
  } reg_state_e;

endpackage

// File: rtl/u712_reg_beat_addr.sv
// Combinational per-beat address/size generator for chip-register sub-cycles.
module u712_reg_beat_addr
  import u712_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [1:0] i_siz,
  input  logic [2:0] i_beat,
  output logic [3:0] o_reg_a,
  output logic [1:0] o_reg_siz,
  output logic       o_last,
  output logic       o_end_long
);

  logic [1:0] w_line_idx;

  // Line beats walk longwords within the 16-byte line, wrapping mod 4.
  assign w_line_idx = i_a[3:2] + i_beat[2:1];

  always_comb begin
    o_reg_a    = i_a;
    o_reg_siz  = i_siz;
    o_last     = (i_beat == LAST_BEAT_SINGLE);
    o_end_long = 1'b0;
    unique case (i_siz)
      SIZ_LONG: begin
        o_reg_a    = {i_a[3:2], i_beat[0], 1'b0};
        o_reg_siz  = SIZ_WORD;
        o_last     = (i_beat == LAST_BEAT_LONG);
        o_end_long = i_beat[0];
      end
      SIZ_LINE: begin
        o_reg_a    = {w_line_idx, i_beat[0], 1'b0};
        o_reg_siz  = SIZ_WORD;
        o_last     = (i_beat == LAST_BEAT_LINE);
        o_end_long = i_beat[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/u712_reg_sizer.sv
// Splits 68040 chip-register transfers into 16-bit sub-cycles for the register engine,
// generating per-beat _TA and the data-half latch/steer strobes.
module u712_reg_sizer
  import u712_pkg::*;
#(
  parameter bit SPLIT_LINE = 1'b1
) (
  input  logic       CLK40,
  input  logic       nRESET,
  input  logic       nTS,
  input  logic       nREGSPACE_CPU,
  input  logic       RnW,
  input  logic [1:0] SIZ,
  input  logic [3:0] A,
  input  logic       REG_TA,
  input  logic       REG_CYCLE,
  output logic       nREGSPACE,
  output logic [3:0] REG_A,
  output logic [1:0] REG_SIZ,
  output logic       REG_RnW,
  output logic       LATCH_HI,
  output logic       LATCH_LO,
  output logic       DRV_HI,
  output logic       nTA,
  output logic       nTEA
);

  reg_state_e r_state, w_state_next;
  logic [3:0] r_a;
  logic [1:0] r_siz;
  logic       r_rnw;
  logic [2:0] r_beat, w_beat_next;
  logic       r_latch_hi, r_latch_lo;

  logic       w_capture, w_sub_active, w_in_xfer, w_req_done;
  logic [3:0] w_reg_a;
  logic [1:0] w_reg_siz;
  logic       w_last, w_end_long;

  u712_reg_beat_addr u_beat_addr (
    .i_a        (r_a),
    .i_siz      (r_siz),
    .i_beat     (r_beat),
    .o_reg_a    (w_reg_a),
    .o_reg_siz  (w_reg_siz),
    .o_last     (w_last),
    .o_end_long (w_end_long)
  );

  assign w_capture  = (r_state == StIdle) && !nTS && !nREGSPACE_CPU;
  assign w_req_done = (r_state == StReq) && REG_TA;

  always_comb begin
    w_state_next = r_state;
    w_beat_next  = r_beat;
    unique case (r_state)
      StIdle: begin
        if (w_capture) begin
          w_beat_next  = 3'd0;
          w_state_next = ((SIZ == SIZ_LINE) && !SPLIT_LINE) ? StErr : StWaitIdle;
        end
      end
      StWaitIdle: if (!REG_CYCLE) w_state_next = StReq;
      StReq:      if (REG_TA) w_state_next = StDrain;
      StDrain: begin
        // The engine stays busy past REG_TA; only move on once it is truly idle.
        if (!REG_CYCLE) begin
          if (w_last || w_end_long) begin
            w_state_next = StAck;
          end else begin
            w_beat_next  = r_beat + 3'd1;
            w_state_next = StWaitIdle;
          end
        end
      end
      StAck: begin
        if (w_last) begin
          w_state_next = StIdle;
        end else begin
          w_beat_next  = r_beat + 3'd1;
          w_state_next = StWaitIdle;
        end
      end
      StErr:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK40 or negedge nRESET) begin
    if (!nRESET) begin
      r_state    <= StIdle;
      r_a        <= 4'h0;
      r_siz      <= SIZ_LONG;
      r_rnw      <= 1'b1;
      r_beat     <= 3'd0;
      r_latch_hi <= 1'b0;
      r_latch_lo <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_beat     <= w_beat_next;
      r_latch_hi <= w_req_done && r_rnw && !w_reg_a[1];
      r_latch_lo <= w_req_done && r_rnw && w_reg_a[1];
      if (w_capture) begin
        r_a   <= A;
        r_siz <= SIZ;
        r_rnw <= RnW;
      end
    end
  end

  assign w_sub_active = (r_state == StWaitIdle) || (r_state == StReq) || (r_state == StDrain);
  assign w_in_xfer    = w_sub_active || (r_state == StAck);

  // Sub-cycle bus shows idle values whenever no transfer is being split.
  assign REG_A     = w_in_xfer ? w_reg_a : 4'h0;
  assign REG_SIZ   = w_in_xfer ? w_reg_siz : 2'b00;
  assign REG_RnW   = w_in_xfer ? r_rnw : 1'b1;
  assign DRV_HI    = w_sub_active && !r_rnw && !w_reg_a[1];
  assign nREGSPACE = (r_state != StReq);
  assign nTA       = (r_state != StAck);
  assign nTEA      = (r_state != StErr);
  assign LATCH_HI  = r_latch_hi;
  assign LATCH_LO  = r_latch_lo;

endmodule

// File: doc/u712_reg_sizer.md
Name: u712_reg_sizer

Overview:
Upstream neighbour of the chipset register (MC68000-style) cycle engine inside U712. It accepts 68040 transfers decoded to chip-register space and splits them into 16-bit sub-cycles. Long transfers become 2 word cycles and line transfers become 8 word cycles; byte and word transfers pass through as 1 cycle. It generates the per-beat CPU _TA and the data-half latch/steer strobes.

Parameters:
SPLIT_LINE, 1, 1 = line transfers split into 8 word sub-cycles; 0 = line transfers terminated with a single nTEA pulse and no sub-cycle.

Ports:
CLK40  in  1  system clock; all logic on posedge
nRESET  in  1  asynchronous active-low reset
nTS  in  1  68040 transfer start, sampled low for one clock
nREGSPACE_CPU  in  1  address decode: current 68040 cycle targets chip registers
RnW  in  1  68040 read/write
SIZ  in  2  68040 size: 00 long, 01 byte, 10 word, 11 line
A  in  4  68040 A[3:0]
REG_TA  in  1  sub-cycle done pulse from register engine (one CLK40 wide)
REG_CYCLE  in  1  register engine busy
nREGSPACE  out  1  sub-cycle request to register engine
REG_A  out  4  sub-cycle address [3:0]
REG_SIZ  out  2  sub-cycle size (68040 encoding)
REG_RnW  out  1  sub-cycle direction
LATCH_HI  out  1  read: capture chip data into D31:16 latch (1-clock pulse)
LATCH_LO  out  1  read: capture chip data into D15:0 latch (1-clock pulse)
DRV_HI  out  1  write: steer D31:16 onto chip data bus (level)
nTA  out  1  CPU transfer acknowledge (1-clock low pulse per beat)
nTEA  out  1  CPU transfer error (1-clock low pulse)

Behaviour:
- Reset values: nREGSPACE=1, nTA=1, nTEA=1, LATCH_HI=LATCH_LO=0, DRV_HI=0, REG_A=0, REG_SIZ=00, REG_RnW=1, FSM=IDLE, beat=0.
- Reset mid-operation: all outputs return to reset values immediately; the aborted transfer is not resumed.
- Capture: in IDLE, nTS=0 and nREGSPACE_CPU=0 latch A, SIZ and RnW. nTS while not IDLE is ignored.
- Beat count: byte/word=1, long=2, line=8 (SPLIT_LINE=1). A 3-bit beat counter runs from 0 to total-1.
- Sub-cycle address:
  - byte/word: REG_A = A and REG_SIZ = SIZ.
  - long/line: REG_SIZ=10, REG_A[0]=0, REG_A[1]=beat[0] (upper half first, big-endian).
  - line: REG_A[3:2] = A[3:2] + beat[2:1] mod 4 (wrap within the 16-byte line).
  - long: REG_A[3:2] = A[3:2].
- FSM states:
  - IDLE: on capture, go to WAITIDLE. If SIZ=11 and SPLIT_LINE=0, go to ERR instead.
  - WAITIDLE: go to REQ when REG_CYCLE=0. No request is ever issued while the engine is busy.
  - REQ: nREGSPACE=0. REG_A, REG_SIZ and REG_RnW stay stable from entry to the exit of DRAIN. On REG_TA=1, set nREGSPACE=1 in the same edge and go to DRAIN.
  - DRAIN: wait for REG_CYCLE=0. Reads end in state 5 and the engine stays busy through state 7, so the next request must not be issued before then. Then:
    - if beat is the last of the transfer, or beat[0]=1 for long/line: go to ACK;
    - otherwise: beat+1 and go to WAITIDLE.
  - ACK: nTA=0 for exactly one clock. If beats remain (line only), beat+1 and go to WAITIDLE; otherwise go to IDLE.
  - ERR: nTEA=0 for one clock, then IDLE.
- Read data: on REG_TA in REQ with REG_RnW=1:
  - pulse LATCH_HI if the half is upper (REG_A[1]=0, or byte/word with A[1]=0);
  - otherwise pulse LATCH_LO.
  - nTA therefore follows the last latch of a beat by ≥1 clock.
- Write data: DRV_HI = REG_A[1]==0 during WAITIDLE/REQ/DRAIN of a write; 0 otherwise.
- REG_TA outside REQ is ignored (no latch, no nTA).
- nTA count per transfer: byte/word/long = 1, line = 4.

Decomposition:
- Shared package u712_pkg: SIZ encodings (SIZ_LONG, SIZ_BYTE, SIZ_WORD, SIZ_LINE), FSM state enum, beat-count constants.
- One natural sub-module: u712_reg_beat_addr. It is combinational: from captured A, SIZ and beat it produces REG_A, REG_SIZ, last-beat and end-of-longword flags.
- The FSM stays in the top of this block.

Test Plan:
- Byte write, A=4'h3, SIZ=01: exactly one nREGSPACE assertion with REG_A=3, REG_SIZ=01, DRV_HI=0; one nTA pulse after REG_TA; no LATCH pulses.
- Long read, A=4'h4: two sub-cycles with REG_A=4 then 6, REG_SIZ=10; LATCH_HI then LATCH_LO; single nTA after LATCH_LO. The second nREGSPACE must not fall while REG_CYCLE=1; hold REG_CYCLE high 5 clocks past REG_TA to check.
- Line write, A=4'hC: 8 sub-cycles with REG_A = C,E,0,2,4,6,8,A (wrap); DRV_HI toggles 1/0; exactly 4 nTA pulses, each after an odd beat.
- SPLIT_LINE=0, line read: nTEA low for 1 clock; nREGSPACE never asserted; returns to IDLE.
- Second nTS during an active long, plus a stray REG_TA in IDLE: both ignored; outputs and beat count unchanged.
- nRESET low during line beat 3 in REQ: nREGSPACE=1, nTA=1, FSM=IDLE asynchronously. A new word read after reset completes normally with one nTA.
